// File: rtl/i2c_seq.sv
// i2c_seq: register write/read sequencer driving the i2c_m START/WR/RESTART/RD/STOP command stream
// Ports: clk, rst (async active-low); req/rnw/dev_addr/reg_addr/wdata request in;
//        busy/done/err/rdata status out; m_ready/m_cmd_done/m_ack/m_rd_out from the master;
//        m_store_cmd/m_cmd/m_din/m_dvsr to the master.
// Optional: define I2C_SEQ_RETRY_EN to retry a NACKed transaction up to RETRIES extra times.
module i2c_seq #(
  parameter logic [15:0] DVSR = 16'd250
`ifdef I2C_SEQ_RETRY_EN
  , parameter int RETRIES = 2
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        rnw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  input  logic        m_ready,
  input  logic        m_cmd_done,
  input  logic        m_ack,
  input  logic [7:0]  m_rd_out,
  output logic        m_store_cmd,
  output logic [2:0]  m_cmd,
  output logic [7:0]  m_din,
  output logic [15:0] m_dvsr
);
  localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3, C_RESTART = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
  state_t state;
  logic rnw_q, err_q, nak;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wd_q, ndin;
  logic [2:0] step, nstep, ncmd, stop_step;
`ifdef I2C_SEQ_RETRY_EN
  logic [31:0] att;
`endif
  assign m_dvsr = DVSR;
  // Steps: write 0 S,1 WR dev,2 WR reg,3 WR data,4 P; read 0 S,1 WR dev,2 WR reg,3 Sr,4 WR dev|1,5 RD,6 P.
  // A NACK after any WR jumps straight to the STOP step.
  always_comb begin
    stop_step = rnw_q ? 3'd6 : 3'd4;
    nak = (m_cmd == C_WR) && m_ack;
    nstep = nak ? stop_step : step + 3'd1;
    ncmd = nstep == stop_step ? C_STOP :
           (rnw_q && nstep == 3'd3) ? C_RESTART :
           (rnw_q && nstep == 3'd5) ? C_RD : C_WR;
    ndin = nstep == 3'd1 ? {dev_q, 1'b0} :
           nstep == 3'd2 ? reg_q :
           (!rnw_q && nstep == 3'd3) ? wd_q :
           (rnw_q && nstep == 3'd4) ? {dev_q, 1'b1} :
           (rnw_q && nstep == 3'd5) ? 8'h01 : 8'h00;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= 8'h00;
      m_store_cmd <= 1'b0;
      m_cmd <= C_START;
      m_din <= 8'h00;
      rnw_q <= 1'b0;
      err_q <= 1'b0;
      dev_q <= 7'd0;
      reg_q <= 8'h00;
      wd_q <= 8'h00;
      step <= 3'd0;
`ifdef I2C_SEQ_RETRY_EN
      att <= 32'd0;
`endif
    end else begin
      m_store_cmd <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          rnw_q <= rnw;
          dev_q <= dev_addr;
          reg_q <= reg_addr;
          wd_q <= wdata;
          step <= 3'd0;
          err_q <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
          att <= 32'd0;
`endif
          m_cmd <= C_START;
          m_din <= 8'h00;
          busy <= 1'b1;
          state <= ISSUE;
        end
      end else if (state == ISSUE) begin
        if (m_ready) begin
          m_store_cmd <= 1'b1;
          state <= WAIT;
        end
      end else if (state == WAIT) begin
        if (m_cmd_done) begin
          if (m_cmd == C_RD) rdata <= m_rd_out;
          if (m_cmd == C_STOP) begin
`ifdef I2C_SEQ_RETRY_EN
            if (err_q && att < 32'(RETRIES)) begin
              att <= att + 32'd1;
              err_q <= 1'b0;
              step <= 3'd0;
              m_cmd <= C_START;
              m_din <= 8'h00;
              state <= ISSUE;
            end else state <= FIN;
`else
            state <= FIN;
`endif
          end else begin
            if (nak) err_q <= 1'b1;
            step <= nstep;
            m_cmd <= ncmd;
            m_din <= ndin;
            state <= ISSUE;
          end
        end
      end else begin
        done <= 1'b1;
        err <= err_q;
        busy <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_i2c_seq.sv
module tb_i2c_seq;
`ifdef I2C_SEQ_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif
  logic clk = 0, rst = 0, req = 0, rnw = 0;
  logic [6:0] dev_addr = 0;
  logic [7:0] reg_addr = 0, wdata = 0;
  logic busy, done, err, m_store_cmd;
  logic [7:0] rdata, m_din;
  logic [2:0] m_cmd;
  logic [15:0] m_dvsr;
  logic m_ready = 1, m_cmd_done = 0, m_ack = 0;
  logic [7:0] m_rd_out = 0;
  int passed = 0, total = 0;
  logic [10:0] exp_q[$];
  int n_cmd = 0, n_start = 0, nack_left = 0, cnt = 0;
  logic pend = 0, nak_now = 0;
  logic [2:0] hold_cmd = 0, last_cmd = 0;
  logic [7:0] hold_din = 0, rd_val = 0;

  always #5 clk = ~clk;

  i2c_seq dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata), .m_ready(m_ready),
    .m_cmd_done(m_cmd_done), .m_ack(m_ack), .m_rd_out(m_rd_out), .m_store_cmd(m_store_cmd),
    .m_cmd(m_cmd), .m_din(m_din), .m_dvsr(m_dvsr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Master model: checks each strobe against the scoreboard, completes it a few cycles later.
  always @(negedge clk) begin
    m_cmd_done = 0;
    m_ack = 0;
    if (!rst) begin
      pend = 0;
      m_ready = 1;
    end else if (m_store_cmd) begin
      chk("strobe_while_pending", pend, 0);
      chk("cmd_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("cmd", {m_cmd, m_din}, exp_q.pop_front());
      nak_now = (m_cmd == 3'd1 && last_cmd == 3'd0 && nack_left > 0);
      if (nak_now) nack_left--;
      if (m_cmd == 3'd0) n_start++;
      n_cmd++;
      last_cmd = m_cmd;
      hold_cmd = m_cmd;
      hold_din = m_din;
      pend = 1;
      cnt = 2;
      m_ready = 0;
    end else if (pend) begin
      if (cnt > 0) cnt--;
      else begin
        chk("cmd_stable", {m_cmd, m_din}, {hold_cmd, hold_din});
        m_cmd_done = 1;
        m_ack = nak_now;
        m_rd_out = rd_val;
        pend = 0;
        m_ready = 1;
      end
    end
  end

  task automatic push_seq(input logic r, input logic [6:0] d, input logic [7:0] rg, input logic [7:0] wd, input logic nak);
    exp_q.push_back({3'd0, 8'h00});
    exp_q.push_back({3'd1, d, 1'b0});
    if (nak) exp_q.push_back({3'd3, 8'h00});
    else begin
      exp_q.push_back({3'd1, rg});
      if (r) begin
        exp_q.push_back({3'd4, 8'h00});
        exp_q.push_back({3'd1, d, 1'b1});
        exp_q.push_back({3'd2, 8'h01});
      end else exp_q.push_back({3'd1, wd});
      exp_q.push_back({3'd3, 8'h00});
    end
  endtask

  task automatic do_req(input logic r, input logic [6:0] d, input logic [7:0] rg, input logic [7:0] wd);
    rnw = r;
    dev_addr = d;
    reg_addr = rg;
    wdata = wd;
    req = 1;
    @(negedge clk);
    req = 0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input logic [7:0] exp_rd);
    int k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int base, k;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_store", m_store_cmd, 0);
    chk("rst_cmd", m_cmd, 0);
    chk("rst_din", m_din, 0);
    chk("dvsr", m_dvsr, 16'd250);
    rst = 1;
    @(negedge clk);
    push_seq(0, 7'h49, 8'h10, 8'hA5, 0);
    do_req(0, 7'h49, 8'h10, 8'hA5);
    wait_done("write", 0, 8'h00);
    rd_val = 8'h5C;
    base = n_cmd;
    push_seq(1, 7'h49, 8'h03, 8'h00, 0);
    do_req(1, 7'h49, 8'h03, 8'h00);
    repeat (6) @(negedge clk);
    rnw = 0;
    dev_addr = 7'h22;
    req = 1;
    @(negedge clk);
    req = 0;
    wait_done("read", 0, 8'h5C);
    chk("read_cmd_count", n_cmd - base, 7);
    nack_left = ATT;
    for (int i = 0; i < ATT; i++) push_seq(0, 7'h49, 8'h10, 8'h11, 1);
    do_req(0, 7'h49, 8'h10, 8'h11);
    wait_done("wr_nack", 1, 8'h5C);
    rd_val = 8'hEE;
    nack_left = ATT;
    for (int i = 0; i < ATT; i++) push_seq(1, 7'h49, 8'h03, 8'h00, 1);
    do_req(1, 7'h49, 8'h03, 8'h00);
    wait_done("rd_nack", 1, 8'h5C);
`ifdef I2C_SEQ_RETRY_EN
    nack_left = 2;
    base = n_start;
    push_seq(0, 7'h49, 8'h10, 8'h66, 1);
    push_seq(0, 7'h49, 8'h10, 8'h66, 1);
    push_seq(0, 7'h49, 8'h10, 8'h66, 0);
    do_req(0, 7'h49, 8'h10, 8'h66);
    wait_done("retry", 0, 8'h5C);
    chk("retry_starts", n_start - base, 3);
`endif
    base = n_cmd;
    push_seq(0, 7'h49, 8'h10, 8'h77, 0);
    do_req(0, 7'h49, 8'h10, 8'h77);
    k = 0;
    while (n_cmd < base + 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wr_reg", n_cmd - base, 3);
    #1 rst = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_store", m_store_cmd, 0);
    chk("mid_rst_cmd", m_cmd, 0);
    chk("mid_rst_din", m_din, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", err, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    push_seq(0, 7'h49, 8'h20, 8'h3C, 0);
    do_req(0, 7'h49, 8'h20, 8'h3C);
    wait_done("post_rst", 0, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
